// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader.
//   state_t    : reader FSM encoding
//   FIFO_DEPTH : capacity of the output skid FIFO; bounds occupancy + in-flight reads
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_stream_reader_skid.sv
// Two-entry output FIFO between the RAM read port and the stream interface.
// The head entry drives oD directly, so oD/oV come straight from flops and
// hold while the consumer stalls.
// Ports:
//   C, nRST  : clock, async active-low reset
//   i_push   : write i_data this cycle (RAM data returning)
//   i_data   : word to store
//   i_rdy    : stream ready; pop = oV & i_rdy
//   o_count  : current occupancy (0..2)
//   oD, oV   : stream data / valid
module ram_stream_skid #(
  parameter int DW = 8
) (
  input  logic          C,
  input  logic          nRST,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_rdy,
  output logic [1:0]    o_count,
  output logic [DW-1:0] oD,
  output logic          oV
);

  logic [1:0]    r_cnt;
  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;
  logic          w_pop;

  assign w_pop   = (r_cnt != 2'd0) & i_rdy;
  assign o_count = r_cnt;
  assign oD      = r_d0;
  assign oV      = (r_cnt != 2'd0);

  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else if (w_pop) begin
      if (r_cnt == 2'd2) begin
        r_d0 <= r_d1;
        if (i_push) r_d1 <= i_data;
        else        r_cnt <= 2'd1;
      end else begin
        // single entry leaving; a concurrent push refills the head directly
        if (i_push) r_d0 <= i_data;
        else        r_cnt <= 2'd0;
      end
    end else if (i_push) begin
      if (r_cnt == 2'd0) begin
        r_d0  <= i_data;
        r_cnt <= 2'd1;
      end else if (r_cnt == 2'd1) begin
        r_d1  <= i_data;
        r_cnt <= 2'd2;
      end
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads LEN consecutive words from a 1-cycle-latency RAM starting at BASE
// (address wraps modulo 2**AW) and streams them out over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for START; LEN=0 requests complete immediately with DONE
// READ  | issuing reads while FIFO occupancy + in-flight read < FIFO_DEPTH
// DRAIN | all reads issued; waiting for the last word to be accepted
//
// Ports:
//   C, nRST        : clock, async active-low reset
//   START/BASE/LEN : transfer request, sampled only in IDLE
//   BUSY, DONE     : transfer in progress / one-cycle completion pulse
//   rA, rWR, rQ    : RAM read port (rWR tied low)
//   oD, oV, iRDY   : output stream
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          C,
  input  logic          nRST,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  input  logic [AW:0]   LEN,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] rA,
  output logic          rWR,
  input  logic [DW-1:0] rQ,
  output logic [DW-1:0] oD,
  output logic          oV,
  input  logic          iRDY
);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_ra;
  logic [AW:0]   r_rem;
  logic          r_inflight;
  logic          r_busy;
  logic          r_done;

  logic [1:0]    w_count;
  logic          w_pop;
  logic [2:0]    w_load;
  logic          w_issue;

  // Occupancy after this cycle's pop plus the read returning next cycle.
  // Counting the pop lets a new read issue every cycle while iRDY stays high.
  assign w_pop   = oV & iRDY;
  assign w_load  = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_issue = (r_state == READ) && (w_load < 3'(FIFO_DEPTH));

  // The RAM samples the address at the end of the issue cycle, so the next
  // address is presented combinationally; otherwise the last one is held.
  assign rA   = w_issue ? r_addr : r_ra;
  assign rWR  = 1'b0;
  assign BUSY = r_busy;
  assign DONE = r_done;

  ram_stream_skid #(.DW(DW)) u_skid (
    .C       (C),
    .nRST    (nRST),
    .i_push  (r_inflight),
    .i_data  (rQ),
    .i_rdy   (iRDY),
    .o_count (w_count),
    .oD      (oD),
    .oV      (oV)
  );

  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_ra       <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_ra   <= r_addr;
        r_addr <= r_addr + AW'(1);
        r_rem  <= r_rem - (AW+1)'(1);
      end
      case (r_state)
        IDLE: begin
          if (START) begin
            if (LEN != '0) begin
              r_state <= READ;
              r_addr  <= BASE;
              r_rem   <= LEN;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_issue && (r_rem == (AW+1)'(1))) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pop && (w_count == 2'd1) && !r_inflight) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: a behavioural RAM (RAM[i]=i),
// a scoreboard queue filled when a transfer is started and drained as the
// stream accepts words, plus directed latency/boundary checks.
module tb_ram_stream_reader;

  logic       C = 1'b0;
  logic       nRST;
  logic       START;
  logic [5:0] BASE;
  logic [6:0] LEN;
  logic       BUSY, DONE, rWR, oV, iRDY;
  logic [5:0] rA;
  logic [7:0] rQ, oD;

  logic [7:0] mem [0:63];
  logic [7:0] exp_q [$];

  int n_cmp  = 0;
  int n_err  = 0;
  int n_acc  = 0;
  int n_done = 0;
  bit rdy_mode = 1'b0;

  ram_stream_reader dut (
    .C(C), .nRST(nRST), .START(START), .BASE(BASE), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .rA(rA), .rWR(rWR), .rQ(rQ),
    .oD(oD), .oV(oV), .iRDY(iRDY)
  );

  always #5 C = ~C;

  initial for (int i = 0; i < 64; i++) mem[i] = 8'(i);
  always @(posedge C) rQ <= mem[rA];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // sole driver of iRDY: held high, or pseudo-random per cycle
  initial begin
    iRDY = 1'b1;
    forever begin
      @(posedge C); #1;
      iRDY = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // stream monitor / scoreboard
  logic       prev_ov, prev_rdy;
  logic [7:0] prev_od;
  logic [7:0] e;
  initial begin prev_ov = 1'b0; prev_rdy = 1'b0; prev_od = '0; end
  always @(negedge C) begin
    if (nRST === 1'b1) begin
      chk("rwr_low", 32'(rWR), 0);
      chk("occ_le2", 32'((32'(dut.w_count) + 32'(dut.r_inflight)) <= 32'd2), 1);
      if (prev_ov && !prev_rdy) begin
        chk("hold_v", 32'(oV), 1);
        chk("hold_d", 32'(oD), 32'(prev_od));
      end
      if (oV && iRDY) begin
        n_acc++;
        if (exp_q.size() == 0) chk("unexpected_word", 32'(oD), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("data", 32'(oD), 32'(e));
        end
      end
      if (DONE) n_done++;
      prev_ov = oV; prev_rdy = iRDY; prev_od = oD;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic start_xfer(input int base, input int len);
    @(posedge C); #1;
    START = 1'b1; BASE = 6'(base); LEN = 7'(len);
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % 64]);
    @(posedge C); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (DONE) seen = 1'b1;
      else begin @(posedge C); #1; end
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    chk({tag, "_busy_fall"}, 32'(BUSY), 0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
    @(posedge C); #1;
    chk({tag, "_done_1cyc"}, 32'(DONE), 0);
  endtask

  initial begin
    int acc0, done0;
    logic [5:0] ra0;
    bit got3;
    START = 1'b0; BASE = '0; LEN = '0;
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_ov", 32'(oV), 0);
    chk("rst_od", 32'(oD), 0);
    chk("rst_ra", 32'(rA), 0);
    repeat (3) @(posedge C);
    #1 nRST = 1'b1;

    // BASE=5 LEN=4, iRDY=1: latency and back-to-back throughput
    start_xfer(5, 4);
    chk("t1_busy", 32'(BUSY), 1);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) chk("t1_ra", 32'(rA), 32'(5 + i));
      chk("t1_ov", 32'(oV), 32'(i >= 2));
      @(posedge C); #1;
    end
    chk("t1_done", 32'(DONE), 1);
    chk("t1_busy_fall", 32'(BUSY), 0);
    chk("t1_ov_end", 32'(oV), 0);
    @(posedge C); #1;
    chk("t1_done_1cyc", 32'(DONE), 0);

    // address wrap
    start_xfer(62, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_ra", 32'(rA), 32'((62 + i) % 64));
      @(posedge C); #1;
    end
    wait_done("t2", 20);

    // LEN=0
    ra0 = rA;
    start_xfer(7, 0);
    chk("t3_done", 32'(DONE), 1);
    chk("t3_busy", 32'(BUSY), 0);
    chk("t3_ra", 32'(rA), 32'(ra0));
    chk("t3_ov", 32'(oV), 0);
    @(posedge C); #1;
    chk("t3_done_1cyc", 32'(DONE), 0);
    chk("t3_ov2", 32'(oV), 0);

    // full-depth transfer with random back-pressure
    rdy_mode = 1'b1;
    acc0 = n_acc;
    start_xfer(17, 64);
    wait_done("t4", 3000);
    chk("t4_count", 32'(n_acc - acc0), 64);
    rdy_mode = 1'b0;

    // reset after the third word of a 10-word transfer
    acc0 = n_acc; done0 = n_done; got3 = 1'b0;
    start_xfer(20, 10);
    for (int i = 0; i < 50 && !got3; i++) begin
      if (n_acc >= acc0 + 3) got3 = 1'b1;
      else begin @(posedge C); #1; end
    end
    chk("t5_third_word", 32'(got3), 1);
    nRST = 1'b0;
    #1;
    chk("t5_busy", 32'(BUSY), 0);
    chk("t5_done", 32'(DONE), 0);
    chk("t5_ov", 32'(oV), 0);
    chk("t5_od", 32'(oD), 0);
    chk("t5_ra", 32'(rA), 0);
    exp_q.delete();
    repeat (2) @(posedge C);
    #1 nRST = 1'b1;
    @(posedge C); #1;
    chk("t5_no_done", 32'(n_done), 32'(done0));
    chk("t5_idle", 32'(BUSY), 0);
    start_xfer(0, 2);
    wait_done("t5b", 20);

    // START during BUSY must be ignored
    done0 = n_done;
    start_xfer(30, 5);
    START = 1'b1; BASE = 6'd0; LEN = 7'd3;
    repeat (2) begin @(posedge C); #1; end
    START = 1'b0;
    wait_done("t6", 30);
    chk("t6_one_done", 32'(n_done - done0), 1);
    repeat (3) begin @(posedge C); #1; end
    chk("t6_still_idle", 32'(BUSY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
